// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the external asynchronous SRAM controller.
package sram_ctrl_pkg;

    // Controller states; 3-bit encoding matches the CPU-side state definitions.
    typedef enum logic [2:0] {
        SRAM_IDLE     = 3'd0,
        SRAM_RD       = 3'd1,
        SRAM_WR_SETUP = 3'd2,
        SRAM_WR_PULSE = 3'd3,
        SRAM_WR_HOLD  = 3'd4
    } sram_state_e;

    localparam int SRAM_ADDR_W   = 18;
    localparam int SRAM_DATA_W   = 16;
    localparam int SRAM_WAIT_DEF = 1;

    // Access-length counter width; limits WAIT_CYCLES to 0..7.
    localparam int SRAM_CNT_W    = 3;

    // Counter reload value for an access phase of wait_cycles+1 clocks.
    function automatic logic [SRAM_CNT_W-1:0] cnt_load(input int wait_cycles);
        return SRAM_CNT_W'(wait_cycles);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Serves single read/write requests from the EXE stage on one external
// asynchronous SRAM. All SRAM pins, including the data-bus enable, are flops.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = SRAM_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wr_done,
    output logic              ram_en,
    output logic              ram_oe,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam logic [SRAM_CNT_W-1:0] CNT_LOAD = cnt_load(WAIT_CYCLES);

    sram_state_e           state;
    logic [SRAM_CNT_W-1:0] cnt;
    logic                  data_oe;
    logic [DATA_W-1:0]     wdata_q;
    logic                  accept;

    assign req_ready = (state == SRAM_IDLE);
    assign busy      = (state != SRAM_IDLE);
    assign accept    = req_valid && (state == SRAM_IDLE);

    // Only the registered enable ever opens the bus; it is low whenever oe is low.
    assign ram_data  = data_oe ? wdata_q : {DATA_W{1'bz}};

    // Write data captured on accept; never needs a reset since data_oe gates it.
    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q <= req_wdata;
        end
    end

    // Access sequencer; strobes are registered so they change one edge after the state decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SRAM_IDLE;
            cnt         <= '0;
            ram_en      <= 1'b1;
            ram_oe      <= 1'b1;
            ram_rw      <= 1'b1;
            ram_addr    <= '0;
            data_oe     <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            wr_done     <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            wr_done     <= 1'b0;
            case (state)
                SRAM_IDLE: begin
                    if (req_valid) begin
                        ram_addr <= req_addr;
                        ram_en   <= 1'b0;
                        cnt      <= CNT_LOAD;
                        if (req_write) begin
                            data_oe <= 1'b1;
                            state   <= SRAM_WR_SETUP;
                        end else begin
                            ram_oe  <= 1'b0;
                            state   <= SRAM_RD;
                        end
                    end
                end
                SRAM_RD: begin
                    if (cnt == '0) begin
                        rdata       <= ram_data;
                        rdata_valid <= 1'b1;
                        ram_en      <= 1'b1;
                        ram_oe      <= 1'b1;
                        state       <= SRAM_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SRAM_WR_SETUP: begin
                    // Address and data have settled for a full cycle before the strobe falls.
                    ram_rw <= 1'b0;
                    state  <= SRAM_WR_PULSE;
                end
                SRAM_WR_PULSE: begin
                    if (cnt == '0) begin
                        ram_rw <= 1'b1;
                        state  <= SRAM_WR_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SRAM_WR_HOLD: begin
                    // Data stays on the bus one cycle past the strobe's rising edge.
                    data_oe <= 1'b0;
                    ram_en  <= 1'b1;
                    wr_done <= 1'b1;
                    state   <= SRAM_IDLE;
                end
                default: begin
                    data_oe <= 1'b0;
                    ram_en  <= 1'b1;
                    ram_oe  <= 1'b1;
                    ram_rw  <= 1'b1;
                    state   <= SRAM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (WAIT_CYCLES=1 and 0), each with its own
// asynchronous SRAM model, checked against an address->data reference map.
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         [2];
    logic        req_valid   [2];
    logic        req_write   [2];
    logic [17:0] req_addr    [2];
    logic [15:0] req_wdata   [2];
    logic        req_ready   [2];
    logic        busy        [2];
    logic [15:0] rdata       [2];
    logic        rdata_valid [2];
    logic        wr_done     [2];
    logic        ram_en      [2];
    logic        ram_oe      [2];
    logic        ram_rw      [2];
    logic [17:0] ram_addr    [2];
    wire  [15:0] ram_data0;
    wire  [15:0] ram_data1;
    logic [15:0] bus         [2];
    logic        dr          [2];

    int checks = 0;
    int errors = 0;
    logic [15:0] ref_mem [int];
    logic [15:0] last_rd [2];
    logic        started = 1'b0;

    sram_ctrl #(.WAIT_CYCLES(1)) u0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
        .busy(busy[0]), .rdata(rdata[0]), .rdata_valid(rdata_valid[0]), .wr_done(wr_done[0]),
        .ram_en(ram_en[0]), .ram_oe(ram_oe[0]), .ram_rw(ram_rw[0]), .ram_addr(ram_addr[0]),
        .ram_data(ram_data0)
    );

    sram_ctrl #(.WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
        .busy(busy[1]), .rdata(rdata[1]), .rdata_valid(rdata_valid[1]), .wr_done(wr_done[1]),
        .ram_en(ram_en[1]), .ram_oe(ram_oe[1]), .ram_rw(ram_rw[1]), .ram_addr(ram_addr[1]),
        .ram_data(ram_data1)
    );

    assign bus[0] = ram_data0;
    assign bus[1] = ram_data1;
    assign dr[0]  = u0.data_oe;
    assign dr[1]  = u1.data_oe;

    // Asynchronous SRAM model 0: drives when selected for read, stores on rising write strobe.
    logic [15:0] m0_mem [0:(1<<18)-1];
    logic        m0_oe;
    logic [15:0] m0_q;
    always_comb begin
        m0_oe = !ram_en[0] && !ram_oe[0] && ram_rw[0];
        m0_q  = m0_mem[ram_addr[0]];
    end
    assign ram_data0 = m0_oe ? m0_q : 16'hzzzz;
    initial begin
        m0_mem[18'h00123] = 16'hBEEF;
        forever begin
            @(posedge ram_rw[0]);
            if (!ram_en[0]) m0_mem[ram_addr[0]] = ram_data0;
        end
    end

    // Asynchronous SRAM model 1.
    logic [15:0] m1_mem [0:(1<<18)-1];
    logic        m1_oe;
    logic [15:0] m1_q;
    always_comb begin
        m1_oe = !ram_en[1] && !ram_oe[1] && ram_rw[1];
        m1_q  = m1_mem[ram_addr[1]];
    end
    assign ram_data1 = m1_oe ? m1_q : 16'hzzzz;
    initial begin
        m1_mem[18'h00123] = 16'hBEEF;
        forever begin
            @(posedge ram_rw[1]);
            if (!ram_en[1]) m1_mem[ram_addr[1]] = ram_data1;
        end
    end

    function automatic int wc(input int u);
        return (u == 0) ? 1 : 0;
    endfunction

    function automatic int key(input int u, input logic [17:0] a);
        return (u << 18) | int'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pins that must never coexist, sampled every cycle outside reset.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (started && rst[u]) begin
                chk("inv_rw_with_oe", 32'(!ram_rw[u] && !ram_oe[u]), 32'd0);
                chk("inv_drive_with_oe", 32'(dr[u] && !ram_oe[u]), 32'd0);
            end
        end
    end

    task automatic idle(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy[u]), 32'd0);
            chk("idle_ready", 32'(req_ready[u]), 32'd1);
            chk("idle_en", 32'(ram_en[u]), 32'd1);
            chk("idle_oe", 32'(ram_oe[u]), 32'd1);
            chk("idle_rw", 32'(ram_rw[u]), 32'd1);
            chk("idle_drv", 32'(dr[u]), 32'd0);
            chk("idle_rvalid", 32'(rdata_valid[u]), 32'd0);
            chk("idle_wdone", 32'(wr_done[u]), 32'd0);
            chk("idle_rdata_hold", 32'(rdata[u]), 32'(last_rd[u]));
        end
    endtask

    // One access from accept to completion; poke>0 pulses a stray read request at that cycle.
    task automatic do_access(input int u, input bit wr, input logic [17:0] a,
                             input logic [15:0] d, input int poke);
        int w;
        int len;
        logic [15:0] exp;
        w   = wc(u);
        len = wr ? w + 4 : w + 2;
        if (wr) begin
            exp = d;
            ref_mem[key(u, a)] = d;
        end else begin
            exp = ref_mem[key(u, a)];
        end
        chk("acc_ready", 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1;
        req_write[u] = wr;
        req_addr[u]  = a;
        req_wdata[u] = d;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k < len) begin
                chk("busy", 32'(busy[u]), 32'd1);
                chk("ready_while_busy", 32'(req_ready[u]), 32'd0);
                chk("en", 32'(ram_en[u]), 32'd0);
                chk("addr", 32'(ram_addr[u]), 32'(a));
                if (wr) begin
                    chk("wr_oe", 32'(ram_oe[u]), 32'd1);
                    chk("wr_drv", 32'(dr[u]), 32'd1);
                    chk("wr_bus", 32'(bus[u]), 32'(d));
                    chk("wr_rw", 32'(ram_rw[u]), (k >= 2 && k <= w + 2) ? 32'd0 : 32'd1);
                    chk("wr_done_early", 32'(wr_done[u]), 32'd0);
                end else begin
                    chk("rd_oe", 32'(ram_oe[u]), 32'd0);
                    chk("rd_rw", 32'(ram_rw[u]), 32'd1);
                    chk("rd_drv", 32'(dr[u]), 32'd0);
                    chk("rd_bus", 32'(bus[u]), 32'(exp));
                    chk("rd_valid_early", 32'(rdata_valid[u]), 32'd0);
                end
            end else begin
                chk("end_busy", 32'(busy[u]), 32'd0);
                chk("end_ready", 32'(req_ready[u]), 32'd1);
                chk("end_en", 32'(ram_en[u]), 32'd1);
                chk("end_oe", 32'(ram_oe[u]), 32'd1);
                chk("end_rw", 32'(ram_rw[u]), 32'd1);
                chk("end_drv", 32'(dr[u]), 32'd0);
                if (wr) begin
                    chk("wr_done", 32'(wr_done[u]), 32'd1);
                    chk("wr_no_rvalid", 32'(rdata_valid[u]), 32'd0);
                end else begin
                    chk("rd_valid", 32'(rdata_valid[u]), 32'd1);
                    chk("rd_no_wdone", 32'(wr_done[u]), 32'd0);
                    chk("rdata", 32'(rdata[u]), 32'(exp));
                    last_rd[u] = exp;
                end
            end
            if (k == 1) begin
                req_valid[u] = 1'b0;
                req_write[u] = 1'($urandom);
                req_addr[u]  = 18'($urandom);
                req_wdata[u] = 16'($urandom);
            end
            if (poke > 0 && k == poke) begin
                req_valid[u] = 1'b1;
                req_write[u] = 1'b0;
                req_addr[u]  = 18'h00010;
            end
            if (poke > 0 && k == poke + 1) req_valid[u] = 1'b0;
        end
    endtask

    // Write that is cut short by reset while the strobe is low.
    task automatic abort_write(input int u, input logic [17:0] a, input logic [15:0] d);
        chk("ab_ready", 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1;
        req_write[u] = 1'b1;
        req_addr[u]  = a;
        req_wdata[u] = d;
        @(negedge clk);
        req_valid[u] = 1'b0;
        chk("ab_setup_rw", 32'(ram_rw[u]), 32'd1);
        @(negedge clk);
        chk("ab_pulse_rw", 32'(ram_rw[u]), 32'd0);
        #2 rst[u] = 1'b0;
        #1;
        chk("ab_rw", 32'(ram_rw[u]), 32'd1);
        chk("ab_en", 32'(ram_en[u]), 32'd1);
        chk("ab_oe", 32'(ram_oe[u]), 32'd1);
        chk("ab_drv", 32'(dr[u]), 32'd0);
        chk("ab_busy", 32'(busy[u]), 32'd0);
        chk("ab_ready_idle", 32'(req_ready[u]), 32'd1);
        chk("ab_rdata", 32'(rdata[u]), 32'd0);
        last_rd[u] = 16'h0000;
        @(negedge clk);
        rst[u] = 1'b1;
    endtask

    logic [17:0] pool [8];

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u]       = 1'b0;
            req_valid[u] = 1'b0;
            req_write[u] = 1'b0;
            req_addr[u]  = '0;
            req_wdata[u] = '0;
            last_rd[u]   = 16'h0000;
            ref_mem[key(u, 18'h00123)] = 16'hBEEF;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_en", 32'(ram_en[u]), 32'd1);
            chk("rst_oe", 32'(ram_oe[u]), 32'd1);
            chk("rst_rw", 32'(ram_rw[u]), 32'd1);
            chk("rst_addr", 32'(ram_addr[u]), 32'd0);
            chk("rst_drv", 32'(dr[u]), 32'd0);
            chk("rst_rdata", 32'(rdata[u]), 32'd0);
            chk("rst_rvalid", 32'(rdata_valid[u]), 32'd0);
            chk("rst_wdone", 32'(wr_done[u]), 32'd0);
            chk("rst_ready", 32'(req_ready[u]), 32'd1);
            chk("rst_busy", 32'(busy[u]), 32'd0);
        end
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        started = 1'b1;
        @(negedge clk);

        for (int u = 0; u < 2; u++) begin
            do_access(u, 1'b0, 18'h00123, 16'h0000, 0);
            idle(u, 1);
            do_access(u, 1'b1, 18'h1A2B0, 16'h5A5A, 0);
            idle(u, 1);
            do_access(u, 1'b0, 18'h1A2B0, 16'h0000, 0);
            idle(u, 1);
            // Read accepted in the wr_done cycle of the preceding write.
            do_access(u, 1'b1, 18'h00001, 16'h1111, 0);
            do_access(u, 1'b0, 18'h00001, 16'h0000, 0);
            idle(u, 1);
        end
        chk("mem0_write", 32'(m0_mem[18'h1A2B0]), 32'h5A5A);
        chk("mem1_write", 32'(m1_mem[18'h1A2B0]), 32'h5A5A);

        do_access(0, 1'b1, 18'h00002, 16'h2222, 2);
        idle(0, 3);
        abort_write(0, 18'h3F000, 16'hDEAD);
        idle(0, 1);
        do_access(0, 1'b0, 18'h00123, 16'h0000, 0);
        idle(0, 1);

        for (int i = 0; i < 8; i++)
            pool[i] = 18'h10000 | 18'(i << 12) | 18'($urandom_range(0, 12'hFFF));
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 8; i++) do_access(u, 1'b1, pool[i], 16'($urandom), 0);
            repeat (30) begin
                do_access(u, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom), 0);
                idle(u, $urandom_range(0, 2));
            end
            idle(u, 1);
        end

        started = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Responder for the CPU's memory-access requests: the EXE stage issues read/write requests and this block serves them on one external asynchronous SRAM (RAM2 data memory).
- Owns the SRAM pins: active-low enable, output-enable and write strobe, 18-bit address and the bidirectional 16-bit data bus.
- Returns read data and completion pulses.
- Raises busy, which stall_ctrl ORs into hold.

Parameters:
ADDR_W, 18, SRAM word-address width
DATA_W, 16, data width
WAIT_CYCLES, 1, extra access cycles beyond the minimum (0..7)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
req_valid  input  1  request present; held until accepted
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
req_ready  output  1  high in IDLE; accept = req_valid & req_ready
busy  output  1  high whenever state != IDLE
rdata  output  DATA_W  last read data, held until next read completes
rdata_valid  output  1  one-cycle pulse, rdata updated
wr_done  output  1  one-cycle pulse, write finished
ram_en  output  1  SRAM chip enable, active low
ram_oe  output  1  SRAM output enable, active low
ram_rw  output  1  SRAM write strobe, active low
ram_addr  output  ADDR_W  SRAM address
ram_data  inout  DATA_W  SRAM data bus

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst).
- Reset: state=IDLE; ram_en=ram_oe=ram_rw=1; ram_addr=0; ram_data=Z; rdata=0; rdata_valid=wr_done=0.
- Reset asserted mid-access aborts immediately, with strobes released asynchronously. Content at the aborted write address is undefined.
- Registered outputs: every SRAM pin and its tri-state enable come from flops. Nothing combinational drives the pins.
- req_ready and busy decode the state register only.
- On accept, addr, wdata and write are latched. Later changes on req_* are ignored.
- req_valid while busy is ignored; there is no queuing.

FSM:
- IDLE: strobes high, bus Z, req_ready=1.
  - Accept with write=0: go to RD_ACCESS.
  - Accept with write=1: go to WR_SETUP.
- RD_ACCESS: en=0, oe=0, rw=1, bus Z.
  - Lasts WAIT_CYCLES+1 cycles, counted by a down-counter loaded on entry.
  - On the final edge: rdata<=ram_data, rdata_valid<=1, go to IDLE (oe/en high in that IDLE cycle).
- WR_SETUP (1 cycle): en=0, oe=1, rw=1, addr and data driven.
- WR_PULSE (WAIT_CYCLES+1 cycles): rw=0, data driven.
- WR_HOLD (1 cycle): rw=1, data still driven.
  - Then go to IDLE with wr_done<=1; the bus goes Z in IDLE.

Timing:
- Read latency: accept in cycle N gives rdata_valid in cycle N+WAIT_CYCLES+2.
- Write latency: accept in cycle N gives wr_done in cycle N+WAIT_CYCLES+4.
- A new request may be accepted in the same cycle that rdata_valid or wr_done is high.
- At least one IDLE cycle separates any two accesses, which guarantees bus turnaround.

Invariants:
- ram_data is never driven while ram_oe=0.
- ram_rw=0 only in WR_PULSE.
- Address is stable for the whole access.

Other:
- Address is passed through unmodified with no wrap logic. Widths are fixed by the parameters.
- Counter is 3 bits; WAIT_CYCLES>7 is illegal.

Decomposition:
- define.v gains:
  - `RamAddr (17:0)
  - `RamData (15:0)
  - state encodings `SramIdle, `SramRd, `SramWrSetup, `SramWrPulse, `SramWrHold (3-bit)
  - `SramWait default
- Single module, no sub-modules. The tri-state is one continuous assign gated by a registered data_oe flop.

Test Plan:
- Read, WAIT_CYCLES=1: model holds 0xBEEF at 0x00123; accept read in cycle 0 -> en/oe low in cycles 1-2, addr=0x00123, rdata=0xBEEF with rdata_valid pulse in cycle 3, bus never driven by DUT.
- Write: accept write 0x1A2B0 <= 0x5A5A in cycle 0 -> setup in cycle 1, rw low in cycles 2-3, hold in cycle 4, wr_done in cycle 5; model memory holds 0x5A5A; data driven only in cycles 1-4.
- Back-to-back: write 0x0001<=0x1111, then read 0x0001 with req_valid held -> read accepted in the wr_done cycle, returns 0x1111, assertion checker finds no oe=0 while driving.
- Busy ignore: pulse req_valid for a read to 0x00010 while a write is in progress -> dropped, no second access, busy high throughout write.
- Reset mid-write: rst low during WR_PULSE -> same-cycle ram_rw=ram_en=1, bus Z, state IDLE; after release, a read returns correct data at an unrelated address.
- WAIT_CYCLES=0: read latency 2, write latency 4; repeat the first two scenarios with matching cycle counts.
